// File: rtl/bit_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serial_adder_pkg
//  Brief    : Shared types and defaults for the bit-serial adder.
//             Holds the FSM state encoding and the default operand width.
//  Revision : 1.0  initial release
// ============================================================================
package bit_serial_adder_pkg;

   // Default operand/result width when the top is instantiated without override
   localparam int DEFAULT_W = 8;

   // Sequencer states: waiting for operands, shifting bits, holding the result
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : bit_serial_adder_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder
//  Brief    : Single-bit full adder cell, purely combinational.
//  Revision : 1.0  initial release
// ============================================================================
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   logic w_half;

   // Classic two-level form: carry propagates through the half-sum
   always_comb begin
      w_half = a ^ b;
      sum    = w_half ^ c;
      carry  = (a & b) | (c & w_half);
   end

endmodule : full_adder
`default_nettype wire

// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serial_adder
//  Brief    : W-bit adder that reuses one full_adder cell, one bit per clock,
//             LSB first. Operands arrive on a valid/ready handshake and the
//             result is offered on a second valid/ready handshake.
//  Config   : BIT_SERIAL_ADDER_SUB_EN adds a sub_in port; when set at
//             acceptance the block computes A-B (cout_out=1 means no borrow).
//  Revision : 1.0  initial release
// ============================================================================
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a_in,
   input  logic [W-1:0] b_in,
   input  logic         cin,
`ifdef BIT_SERIAL_ADDER_SUB_EN
   input  logic         sub_in,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum_out,
   output logic         cout_out,
   output logic         busy
);

   // Counter is wide enough to hold W, so W=1 still gets a 1-bit counter
   localparam int                c_cnt_w    = $clog2(W + 1);
   localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(W - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_cnt_w-1:0]   r_count;
   logic [W-1:0]         r_a_sh;
   logic [W-1:0]         r_b_sh;
   logic [W-1:0]         r_sum_sh;
   logic                 r_carry;
   logic [W-1:0]         r_sum_q;
   logic                 r_cout_q;

   logic                 w_accept;
   logic                 w_last;
   logic                 w_fa_sum;
   logic                 w_fa_carry;
   logic [W-1:0]         w_b_cap;
   logic                 w_c_cap;
   logic [W-1:0]         w_sum_shift;

   assign w_accept = in_valid && (r_state == IDLE);
   assign w_last   = (r_count == c_last_cnt);

`ifdef BIT_SERIAL_ADDER_SUB_EN
   // Subtraction is A + ~B + 1, so the captured carry is forced high
   assign w_b_cap = sub_in ? ~b_in : b_in;
   assign w_c_cap = sub_in ? 1'b1  : cin;
`else
   assign w_b_cap = b_in;
   assign w_c_cap = cin;
`endif

   // The new sum bit enters at the MSB; written with shifts so W=1 is legal
   assign w_sum_shift = (r_sum_sh >> 1) | (W'(w_fa_sum) << (W - 1));

   full_adder u_fa (
      .a     (r_a_sh[0]),
      .b     (r_b_sh[0]),
      .c     (r_carry),
      .sum   (w_fa_sum),
      .carry (w_fa_carry)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state: one pass through RUN per operand bit, then wait for hand-off
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept)  w_state_nxt = RUN;
         RUN:     if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default:                w_state_nxt = IDLE;
      endcase
   end

   // Output decode: handshakes follow the state directly
   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
      busy      = (r_state == RUN) || (r_state == DONE);
   end

   // Datapath: capture on accept, shift one bit per RUN edge, latch result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= '0;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_carry  <= 1'b0;
         r_sum_q  <= '0;
         r_cout_q <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a_sh  <= a_in;
                  r_b_sh  <= w_b_cap;
                  r_carry <= w_c_cap;
                  r_count <= '0;
               end
            end
            RUN: begin
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_sum_sh <= w_sum_shift;
               r_carry  <= w_fa_carry;
               r_count  <= r_count + c_cnt_w'(1);
               // Result registers only change here, so they stay put in
               // DONE and keep their value back in IDLE
               if (w_last) begin
                  r_sum_q  <= w_sum_shift;
                  r_cout_q <= w_fa_carry;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum_out  = r_sum_q;
   assign cout_out = r_cout_q;

endmodule : bit_serial_adder
`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_serial_adder
//  Brief    : Self-checking bench for bit_serial_adder (W=8 and W=1 copies)
//             against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bit_serial_adder;

   logic       clk;
   logic       rst_n;

   // W=8 instance
   logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
   logic [7:0] a8, b8, sum8;
   logic       sub8;
   // W=1 instance
   logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
   logic [0:0] a1, b1, sum1;
   logic       sub1;

   int n_checks;
   int n_pass;

   bit_serial_adder #(.W(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a_in      (a8),
      .b_in      (b8),
      .cin       (cin8),
`ifdef BIT_SERIAL_ADDER_SUB_EN
      .sub_in    (sub8),
`endif
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .sum_out   (sum8),
      .cout_out  (cout8),
      .busy      (busy8)
   );

   bit_serial_adder #(.W(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a_in      (a1),
      .b_in      (b1),
      .cin       (cin1),
`ifdef BIT_SERIAL_ADDER_SUB_EN
      .sub_in    (sub1),
`endif
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .sum_out   (sum1),
      .cout_out  (cout1),
      .busy      (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain arithmetic on the operands (9-bit result)
   function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic s);
      logic [8:0] r;
      if (s) r = {1'b0, a} + {1'b0, ~b} + 9'd1;
      else   r = {1'b0, a} + {1'b0, b} + {8'd0, c};
      return r;
   endfunction

   // One W=8 transaction. edges counts clock edges from and including the
   // accepting edge up to and including the edge on which out_valid rises.
   task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic s, output logic [7:0] sum, output logic co,
                          output int edges);
      in_valid8 = 1'b1; a8 = a; b8 = b; cin8 = c; sub8 = s;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      edges = 1;
      while (!out_valid8 && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      sum = sum8; co = cout8;
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
   endtask

   task automatic run_op1(input logic a, input logic b, input logic c,
                          output logic sum, output logic co, output int edges);
      in_valid1 = 1'b1; a1 = a; b1 = b; cin1 = c;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      edges = 1;
      while (!out_valid1 && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      sum = sum1[0]; co = cout1;
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({in_ready8, out_valid8, busy8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
         $display("FAIL reset8: got rdy=%b vld=%b busy=%b co=%b sum=%h, want 1 0 0 0 00",
                  in_ready8, out_valid8, busy8, cout8, sum8);
      else n_pass++;
      n_checks++;
      if ({in_ready1, out_valid1, busy1, cout1, sum1} !== 5'b10000)
         $display("FAIL reset1: got rdy=%b vld=%b busy=%b co=%b sum=%b, want 1 0 0 0 0",
                  in_ready1, out_valid1, busy1, cout1, sum1);
      else n_pass++;
   endtask

   task automatic test_directed();
      logic [7:0] s; logic co; int e;
      logic [7:0] va [3] = '{8'h00, 8'hFF, 8'h5A};
      logic [7:0] vb [3] = '{8'h00, 8'h01, 8'hA5};
      logic       vc [3] = '{1'b0, 1'b0, 1'b1};
      logic [8:0] want [3] = '{9'h000, 9'h100, 9'h100};
      for (int i = 0; i < 3; i++) begin
         run_op8(va[i], vb[i], vc[i], 1'b0, s, co, e);
         n_checks++;
         if ({co, s} !== want[i])
            $display("FAIL directed%0d: got co=%b sum=%h, want co=%b sum=%h",
                     i, co, s, want[i][8], want[i][7:0]);
         else n_pass++;
         n_checks++;
         if (e !== 9)
            $display("FAIL latency%0d: got %0d edges, want 9", i, e);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [7:0] a, b, s; logic c, co; int e;
      logic [8:0] want;
      for (int i = 0; i < 20; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         c = 1'($urandom_range(0, 1));
         want = model8(a, b, c, 1'b0);
         run_op8(a, b, c, 1'b0, s, co, e);
         n_checks++;
         if ({co, s} !== want || e !== 9)
            $display("FAIL random%0d a=%h b=%h c=%b: got co=%b sum=%h edges=%0d, want co=%b sum=%h edges=9",
                     i, a, b, c, co, s, e, want[8], want[7:0]);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int e;
      logic [8:0] want;
      want = model8(8'h3C, 8'h0F, 1'b0, 1'b0);
      in_valid8 = 1'b1; a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0; sub8 = 1'b0;
      @(posedge clk); #1;
      // in_valid stays high with new operands: must be ignored while busy
      a8 = 8'hE7; b8 = 8'h99; cin8 = 1'b1;
      e = 1;
      while (!out_valid8 && e < 40) begin
         @(posedge clk); #1;
         e++;
      end
      n_checks++;
      if ({cout8, sum8} !== want || e !== 9)
         $display("FAIL bp_result: got co=%b sum=%h edges=%0d, want co=%b sum=%h edges=9",
                  cout8, sum8, e, want[8], want[7:0]);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({out_valid8, in_ready8, busy8, cout8, sum8} !== {1'b1, 1'b0, 1'b1, want})
            $display("FAIL bp_hold%0d: got vld=%b rdy=%b busy=%b co=%b sum=%h, want 1 0 1 %b %h",
                     i, out_valid8, in_ready8, busy8, cout8, sum8, want[8], want[7:0]);
         else n_pass++;
      end
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      n_checks++;
      if ({out_valid8, in_ready8, busy8, cout8, sum8} !== {1'b0, 1'b1, 1'b0, want})
         $display("FAIL bp_release: got vld=%b rdy=%b busy=%b co=%b sum=%h, want 0 1 0 %b %h",
                  out_valid8, in_ready8, busy8, cout8, sum8, want[8], want[7:0]);
      else n_pass++;
   endtask

   task automatic test_reset_midrun();
      logic [7:0] s; logic co; int e;
      bit seen;
      in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h77; cin8 = 1'b1; sub8 = 1'b0;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready8, out_valid8, busy8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
         $display("FAIL midrun_reset: got rdy=%b vld=%b busy=%b co=%b sum=%h, want 1 0 0 0 00",
                  in_ready8, out_valid8, busy8, cout8, sum8);
      else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid8) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0)
         $display("FAIL midrun_no_output: got out_valid seen=%b, want 0", seen);
      else n_pass++;
      run_op8(8'h03, 8'h04, 1'b0, 1'b0, s, co, e);
      n_checks++;
      if ({co, s} !== 9'h007 || e !== 9)
         $display("FAIL midrun_after: got co=%b sum=%h edges=%0d, want co=0 sum=07 edges=9", co, s, e);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] s; logic co; int e;
      logic [8:0] want;
      // run_op8 returns one edge after hand-off, i.e. straight after the bubble
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (in_ready8 !== 1'b1)
            $display("FAIL b2b_ready%0d: got in_ready=%b, want 1", i, in_ready8);
         else n_pass++;
         want = model8(8'h80 + 8'(i), 8'h81, 1'b1, 1'b0);
         run_op8(8'h80 + 8'(i), 8'h81, 1'b1, 1'b0, s, co, e);
         n_checks++;
         if ({co, s} !== want || e !== 9)
            $display("FAIL b2b%0d: got co=%b sum=%h edges=%0d, want co=%b sum=%h edges=9",
                     i, co, s, e, want[8], want[7:0]);
         else n_pass++;
      end
   endtask

`ifdef BIT_SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      logic [7:0] s; logic co; int e;
      logic [7:0] a, b;
      logic [8:0] want;
      run_op8(8'h10, 8'h01, 1'b0, 1'b1, s, co, e);
      n_checks++;
      if ({co, s} !== 9'h10F)
         $display("FAIL sub_10_01: got co=%b sum=%h, want co=1 sum=0f", co, s);
      else n_pass++;
      run_op8(8'h01, 8'h02, 1'b1, 1'b1, s, co, e);
      n_checks++;
      if ({co, s} !== 9'h0FF)
         $display("FAIL sub_01_02: got co=%b sum=%h, want co=0 sum=ff", co, s);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         want = {(a >= b), 8'(a - b)};
         run_op8(a, b, 1'($urandom_range(0, 1)), 1'b1, s, co, e);
         n_checks++;
         if ({co, s} !== want)
            $display("FAIL sub_rand%0d a=%h b=%h: got co=%b sum=%h, want co=%b sum=%h",
                     i, a, b, co, s, want[8], want[7:0]);
         else n_pass++;
      end
   endtask
`endif

   task automatic test_w1();
      logic s, co; int e;
      int tot;
      run_op1(1'b1, 1'b1, 1'b1, s, co, e);
      n_checks++;
      if ({co, s} !== 2'b11 || e !== 2)
         $display("FAIL w1_111: got co=%b sum=%b edges=%0d, want co=1 sum=1 edges=2", co, s, e);
      else n_pass++;
      for (int v = 0; v < 8; v++) begin
         tot = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
         run_op1(1'(v >> 2), 1'(v >> 1), 1'(v), s, co, e);
         n_checks++;
         if ({co, s} !== 2'(tot) || e !== 2)
            $display("FAIL w1_combo%0d: got co=%b sum=%b edges=%0d, want %0d edges=2",
                     v, co, s, e, tot);
         else n_pass++;
      end
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      rst_n = 1'b0;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b0;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_directed();
      test_random();
      test_backpressure();
      test_reset_midrun();
      test_back_to_back();
`ifdef BIT_SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      test_w1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_bit_serial_adder
`default_nettype wire
